// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and the load/store unit.
// Data wins by default; a counter forces a fetch after STARVE_LIMIT data grants.
module mem_port_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  input  logic        if_flush,
  output logic [31:0] if_rdata,
  output logic        if_ack,
  output logic        if_wait,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [3:0]  dm_be,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic [31:0] dm_rdata,
  output logic        dm_ack,
  output logic        dm_wait,
  output logic        mem_req,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready
);
  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_DM, RESP} state_t;
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t     state, state_nxt;
  logic [3:0] starve_cnt;
  logic       kill, resp_if;
  logic       if_ok, grant_if, grant_dm;

  assign if_ok    = if_req && !if_flush;
  assign grant_if = (state == IDLE) && if_ok && (!dm_req || starve_cnt == LIMIT);
  assign grant_dm = (state == IDLE) && dm_req && !grant_if;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (grant_if)      state_nxt = BUSY_IF;
        else if (grant_dm) state_nxt = BUSY_DM;
      end
      BUSY_IF, BUSY_DM: if (mem_ready) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // A killed fetch still finishes on the bus but is never acknowledged.
  always_comb begin
    if_ack = 1'b0;
    dm_ack = 1'b0;
    if (state == RESP) begin
      if_ack = resp_if && !kill && !if_flush;
      dm_ack = !resp_if;
    end
  end

  assign if_wait = if_req && !if_ack;
  assign dm_wait = dm_req && !dm_ack;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_be     <= 4'h0;
      mem_addr   <= 32'h0;
      mem_wdata  <= 32'h0;
      if_rdata   <= 32'h0;
      dm_rdata   <= 32'h0;
      starve_cnt <= 4'h0;
      kill       <= 1'b0;
      resp_if    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_if) begin
            mem_req    <= 1'b1;
            mem_we     <= 1'b0;
            mem_be     <= 4'hF;
            mem_addr   <= if_addr;
            mem_wdata  <= 32'h0;
            resp_if    <= 1'b1;
            starve_cnt <= 4'h0;
          end else if (grant_dm) begin
            mem_req   <= 1'b1;
            mem_we    <= dm_we;
            mem_be    <= dm_be;
            mem_addr  <= dm_addr;
            mem_wdata <= dm_wdata;
            resp_if   <= 1'b0;
            // Only data grants that pass over a waiting fetch count toward starvation.
            if (if_req) starve_cnt <= (starve_cnt == LIMIT) ? LIMIT : starve_cnt + 4'd1;
            else        starve_cnt <= 4'h0;
          end else if (!if_req) begin
            starve_cnt <= 4'h0;
          end
        end
        BUSY_IF, BUSY_DM: begin
          if (state == BUSY_IF && if_flush) kill <= 1'b1;
          if (mem_ready) begin
            mem_req <= 1'b0;
            if (state == BUSY_IF) if_rdata <= mem_rdata;
            else                  dm_rdata <= mem_we ? 32'h0 : mem_rdata;
          end
        end
        RESP:    kill <= 1'b0;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed vector table, multi-cycle corner
// sequences, then random traffic against a transaction-level port model.
module tb_mem_port_arbiter;
  localparam int LIMIT = 2;
  localparam int NV    = 19;
  localparam int NRAND = 3000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req, if_flush, if_ack, if_wait;
  logic [31:0] if_addr, if_rdata;
  logic        dm_req, dm_we, dm_ack, dm_wait;
  logic [3:0]  dm_be;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic        mem_req, mem_we, mem_ready;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_rdata(if_rdata), .if_ack(if_ack), .if_wait(if_wait),
    .dm_req(dm_req), .dm_we(dm_we), .dm_be(dm_be), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .dm_ack(dm_ack), .dm_wait(dm_wait),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  typedef struct {
    logic        if_req;
    logic [31:0] if_addr;
    logic        dm_req, dm_we;
    logic [3:0]  dm_be;
    logic [31:0] dm_addr, dm_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        x_mem_req, x_mem_we;
    logic [3:0]  x_mem_be;
    logic [31:0] x_mem_addr, x_mem_wdata;
    logic        x_if_ack, x_dm_ack, x_if_wait, x_dm_wait;
    logic [31:0] x_rdata;
  } vec_t;

  vec_t tab[NV];

  function automatic vec_t mk(input int ir, ia, dr, dw, db, da, dwd, rdy, rd,
                              input int xr, xw, xb, xa, xwd, xia, xda, xiw, xdw, xrd);
    vec_t v;
    v.if_req = 1'(ir);    v.if_addr = 32'(ia);
    v.dm_req = 1'(dr);    v.dm_we = 1'(dw);     v.dm_be = 4'(db);
    v.dm_addr = 32'(da);  v.dm_wdata = 32'(dwd);
    v.mem_ready = 1'(rdy); v.mem_rdata = 32'(rd);
    v.x_mem_req = 1'(xr); v.x_mem_we = 1'(xw);  v.x_mem_be = 4'(xb);
    v.x_mem_addr = 32'(xa); v.x_mem_wdata = 32'(xwd);
    v.x_if_ack = 1'(xia); v.x_dm_ack = 1'(xda);
    v.x_if_wait = 1'(xiw); v.x_dm_wait = 1'(xdw); v.x_rdata = 32'(xrd);
    return v;
  endfunction

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk1({tag, ".mem_req"}, mem_req, 1'b0);
    chk1({tag, ".mem_we"},  mem_we,  1'b0);
    chk1({tag, ".if_ack"},  if_ack,  1'b0);
    chk1({tag, ".dm_ack"},  dm_ack,  1'b0);
    chk32({tag, ".mem_be"},    {28'h0, mem_be}, 32'h0);
    chk32({tag, ".mem_addr"},  mem_addr,  32'h0);
    chk32({tag, ".mem_wdata"}, mem_wdata, 32'h0);
    chk32({tag, ".if_rdata"},  if_rdata,  32'h0);
    chk32({tag, ".dm_rdata"},  dm_rdata,  32'h0);
  endtask

  task automatic idle_in();
    if_req = 1'b0; if_flush = 1'b0; if_addr = 32'h0;
    dm_req = 1'b0; dm_we = 1'b0; dm_be = 4'h0; dm_addr = 32'h0; dm_wdata = 32'h0;
    mem_ready = 1'b0; mem_rdata = 32'h0;
  endtask

  // Serve both requesters with zero-wait memory until nothing is outstanding.
  task automatic drain(input string tag);
    logic ia, da;
    ia = 1'b0; da = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (ia) if_req = 1'b0;
      if (da) dm_req = 1'b0;
      if (!if_req && !dm_req && !mem_req) break;
      mem_ready = mem_req;
      mem_rdata = 32'h0;
      #1;
      ia = if_ack; da = dm_ack;
    end
    mem_ready = 1'b0;
    chk1({tag, ".drained"}, !if_req && !dm_req && !mem_req, 1'b1);
  endtask

  // Random-phase model: who owns the port, who is being answered, starvation streak.
  int          m_own, m_resp, m_streak;
  bit          m_kill;
  logic        m_we;
  logic [3:0]  m_be;
  logic [31:0] m_addr, m_wdata, m_if_data, m_dm_data;
  bit          p_if_ack, p_dm_ack, p_flush;
  logic        e_if_ack, e_dm_ack;
  bit          gq[$];
  bit          exp_order[6];
  logic        prev_mreq;

  task automatic model_edge();
    if (m_resp != 0) begin
      m_resp = 0;
      m_kill = 0;
    end else if (m_own != 0) begin
      if (m_own == 1 && if_flush) m_kill = 1;
      if (mem_ready) begin
        if (m_own == 1) m_if_data = mem_rdata;
        else            m_dm_data = m_we ? 32'h0 : mem_rdata;
        m_resp = m_own;
        m_own  = 0;
      end
    end else begin
      // A live fetch wins when alone, or after being passed over LIMIT times.
      if (if_req && !if_flush && (!dm_req || m_streak == LIMIT)) begin
        m_own = 1; m_we = 1'b0; m_be = 4'hF; m_addr = if_addr; m_wdata = 32'h0;
        m_streak = 0;
      end else if (dm_req) begin
        m_own = 2; m_we = dm_we; m_be = dm_be; m_addr = dm_addr; m_wdata = dm_wdata;
        m_streak = if_req ? ((m_streak + 1 > LIMIT) ? LIMIT : m_streak + 1) : 0;
      end else if (!if_req) begin
        m_streak = 0;
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tab[0]  = mk(1, 'h100, 0, 0, 0, 0, 0, 0, 0,                 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    tab[1]  = mk(1, 'h100, 0, 0, 0, 0, 0, 1, 'h00500093,        1, 0, 'hF, 'h100, 0, 0, 0, 1, 0, 0);
    tab[2]  = mk(1, 'h100, 0, 0, 0, 0, 0, 0, 0,                 0, 0, 0, 0, 0, 1, 0, 0, 0, 'h00500093);
    tab[3]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0,                     0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tab[4]  = mk(1, 'h200, 1, 1, 3, 'h2000, 'hDEADBEEF, 0, 0,   0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    tab[5]  = mk(1, 'h200, 1, 1, 3, 'h2000, 'hDEADBEEF, 1, 'h55, 1, 1, 3, 'h2000, 'hDEADBEEF, 0, 0, 1, 1, 0);
    tab[6]  = mk(1, 'h200, 1, 1, 3, 'h2000, 'hDEADBEEF, 0, 0,   0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
    tab[7]  = mk(1, 'h200, 0, 0, 0, 0, 0, 0, 0,                 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    tab[8]  = mk(1, 'h200, 0, 0, 0, 0, 0, 1, 'h00A00113,        1, 0, 'hF, 'h200, 0, 0, 0, 1, 0, 0);
    tab[9]  = mk(1, 'h200, 0, 0, 0, 0, 0, 0, 0,                 0, 0, 0, 0, 0, 1, 0, 0, 0, 'h00A00113);
    tab[10] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0,                     0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tab[11] = mk(0, 0, 1, 0, 'hF, 'h3000, 0, 0, 0,              0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    for (int i = 12; i < 16; i++)
      tab[i] = mk(0, 0, 1, 0, 'hF, 'h3000, 0, 0, 0,            1, 0, 'hF, 'h3000, 0, 0, 0, 0, 1, 0);
    tab[16] = mk(0, 0, 1, 0, 'hF, 'h3000, 0, 1, 'h12345678,     1, 0, 'hF, 'h3000, 0, 0, 0, 0, 1, 0);
    tab[17] = mk(0, 0, 1, 0, 'hF, 'h3000, 0, 0, 0,              0, 0, 0, 0, 0, 0, 1, 0, 0, 'h12345678);
    tab[18] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0,                     0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    exp_order = '{0, 0, 1, 0, 0, 1};

    rst_n = 1'b0;
    idle_in();
    repeat (2) @(negedge clk);
    chk_reset("reset");
    rst_n = 1'b1;

    // Directed table: fetch, contention with store, load with wait states.
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      if_req = tab[i].if_req;     if_addr = tab[i].if_addr;  if_flush = 1'b0;
      dm_req = tab[i].dm_req;     dm_we = tab[i].dm_we;      dm_be = tab[i].dm_be;
      dm_addr = tab[i].dm_addr;   dm_wdata = tab[i].dm_wdata;
      mem_ready = tab[i].mem_ready; mem_rdata = tab[i].mem_rdata;
      #1;
      chk1($sformatf("vec%0d.mem_req", i), mem_req, tab[i].x_mem_req);
      chk1($sformatf("vec%0d.if_ack", i),  if_ack,  tab[i].x_if_ack);
      chk1($sformatf("vec%0d.dm_ack", i),  dm_ack,  tab[i].x_dm_ack);
      chk1($sformatf("vec%0d.if_wait", i), if_wait, tab[i].x_if_wait);
      chk1($sformatf("vec%0d.dm_wait", i), dm_wait, tab[i].x_dm_wait);
      if (tab[i].x_mem_req) begin
        chk1($sformatf("vec%0d.mem_we", i), mem_we, tab[i].x_mem_we);
        chk32($sformatf("vec%0d.mem_be", i), {28'h0, mem_be}, {28'h0, tab[i].x_mem_be});
        chk32($sformatf("vec%0d.mem_addr", i), mem_addr, tab[i].x_mem_addr);
        if (tab[i].x_mem_we) chk32($sformatf("vec%0d.mem_wdata", i), mem_wdata, tab[i].x_mem_wdata);
      end
      if (tab[i].x_if_ack) chk32($sformatf("vec%0d.if_rdata", i), if_rdata, tab[i].x_rdata);
      if (tab[i].x_dm_ack) chk32($sformatf("vec%0d.dm_rdata", i), dm_rdata, tab[i].x_rdata);
    end

    // Starvation: fetch held, data re-requested back to back.
    if_req = 1'b1; if_addr = 32'h400;
    dm_req = 1'b1; dm_we = 1'b0; dm_be = 4'hF; dm_addr = 32'h5000; dm_wdata = 32'h0;
    prev_mreq = 1'b0;
    for (int c = 0; c < 40 && gq.size() < 6; c++) begin
      @(negedge clk);
      mem_ready = mem_req;
      mem_rdata = 32'(c);
      #1;
      if (mem_req && !prev_mreq) gq.push_back(mem_addr == 32'h400);
      prev_mreq = mem_req;
    end
    chk32("starve.grants", 32'(gq.size()), 32'd6);
    for (int i = 0; i < gq.size() && i < 6; i++)
      chk1($sformatf("starve.grant%0d_is_if", i), gq[i], exp_order[i]);
    drain("starve");

    // Flush in the middle of a slow fetch, then a redirected fetch.
    if_req = 1'b1; if_addr = 32'h600;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if_flush  = (c == 1);
      if (c >= 2) if_addr = 32'h700;
      if (c >= 9) if_req = 1'b0;
      mem_ready = (c == 4) || (c == 7);
      mem_rdata = (c == 4) ? 32'hBAD0BAD0 : 32'h00C00193;
      #1;
      if (c >= 1 && c <= 4) begin
        chk1($sformatf("flush.c%0d.mem_req", c), mem_req, 1'b1);
        chk32($sformatf("flush.c%0d.mem_addr", c), mem_addr, 32'h600);
      end
      if (c == 5 || c == 6) chk1($sformatf("flush.c%0d.mem_req", c), mem_req, 1'b0);
      if (c == 5) chk1("flush.c5.if_wait", if_wait, 1'b1);
      if (c <= 7) chk1($sformatf("flush.c%0d.if_ack", c), if_ack, 1'b0);
      if (c == 7) begin
        chk1("flush.c7.mem_req", mem_req, 1'b1);
        chk32("flush.c7.mem_addr", mem_addr, 32'h700);
      end
      if (c == 8) begin
        chk1("flush.c8.if_ack", if_ack, 1'b1);
        chk32("flush.c8.if_rdata", if_rdata, 32'h00C00193);
      end
    end
    mem_ready = 1'b0;

    // Reset while a load is waiting on memory.
    dm_req = 1'b1; dm_we = 1'b0; dm_be = 4'hF; dm_addr = 32'h800;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk1("rstmid.busy.mem_req", mem_req, 1'b1);
    chk32("rstmid.busy.mem_addr", mem_addr, 32'h800);
    rst_n = 1'b0;
    #1;
    chk_reset("rstmid");
    dm_req = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    if_req = 1'b1; if_addr = 32'h900;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (c >= 3) if_req = 1'b0;
      mem_ready = (c == 1);
      mem_rdata = 32'h01234567;
      #1;
      chk1($sformatf("rstmid.after.c%0d.dm_ack", c), dm_ack, 1'b0);
      if (c == 1) begin
        chk1("rstmid.after.mem_req", mem_req, 1'b1);
        chk32("rstmid.after.mem_addr", mem_addr, 32'h900);
      end
      if (c == 2) begin
        chk1("rstmid.after.if_ack", if_ack, 1'b1);
        chk32("rstmid.after.if_rdata", if_rdata, 32'h01234567);
      end
    end

    // Random traffic against the model, starting from a clean reset.
    @(negedge clk);
    rst_n = 1'b0;
    idle_in();
    @(negedge clk);
    rst_n = 1'b1;
    m_own = 0; m_resp = 0; m_streak = 0; m_kill = 0;
    m_we = 1'b0; m_be = 4'h0; m_addr = 32'h0; m_wdata = 32'h0;
    m_if_data = 32'h0; m_dm_data = 32'h0;
    p_if_ack = 0; p_dm_ack = 0; p_flush = 0;
    for (int c = 0; c < NRAND; c++) begin
      @(negedge clk);
      if (p_flush && if_req)  if_addr = $urandom & 32'hFFFF_FFFC;
      else if (p_if_ack) begin
        if_req = 1'($urandom_range(0, 1)); if_addr = $urandom & 32'hFFFF_FFFC;
      end else if (!if_req) begin
        if_req = ($urandom_range(0, 3) == 0); if_addr = $urandom & 32'hFFFF_FFFC;
      end
      if (p_dm_ack || !dm_req) begin
        dm_req   = p_dm_ack ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 2) == 0);
        dm_we    = 1'($urandom);
        dm_be    = 4'($urandom);
        dm_addr  = $urandom;
        dm_wdata = $urandom;
      end
      if_flush  = ($urandom_range(0, 11) == 0);
      mem_ready = (m_own != 0) && ($urandom_range(0, 2) == 0);
      mem_rdata = $urandom;
      #1;
      e_if_ack = (m_resp == 1) && !m_kill && !if_flush;
      e_dm_ack = (m_resp == 2);
      chk1($sformatf("rnd%0d.mem_req", c), mem_req, m_own != 0);
      chk1($sformatf("rnd%0d.if_ack", c),  if_ack,  e_if_ack);
      chk1($sformatf("rnd%0d.dm_ack", c),  dm_ack,  e_dm_ack);
      chk1($sformatf("rnd%0d.if_wait", c), if_wait, if_req && !e_if_ack);
      chk1($sformatf("rnd%0d.dm_wait", c), dm_wait, dm_req && !e_dm_ack);
      if (m_own != 0) begin
        chk32($sformatf("rnd%0d.mem_addr", c), mem_addr, m_addr);
        chk1($sformatf("rnd%0d.mem_we", c), mem_we, m_we);
        chk32($sformatf("rnd%0d.mem_be", c), {28'h0, mem_be}, {28'h0, m_be});
        if (m_we) chk32($sformatf("rnd%0d.mem_wdata", c), mem_wdata, m_wdata);
      end
      if (e_if_ack) chk32($sformatf("rnd%0d.if_rdata", c), if_rdata, m_if_data);
      if (e_dm_ack) chk32($sformatf("rnd%0d.dm_rdata", c), dm_rdata, m_dm_data);
      p_if_ack = e_if_ack;
      p_dm_ack = e_dm_ack;
      p_flush  = if_flush;
      model_edge();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
